// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
//   Leaf cell of the ripple-carry adder: adds two single bits.
//
// Ports
//   a  in   1  first addend bit
//   b  in   1  second addend bit
//   s  out  1  sum bit,   a ^ b
//   c  out  1  carry bit, a & b
// -----------------------------------------------------------------------------
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Unsigned ripple-carry adder computing {Cout, S} = A + B + Cin.
//   The default WIDTH of 1 gives the classic 1-bit full adder. The sum and
//   carry are purely combinational. A registered copy (S_q / Cout_q) is
//   provided for pipelined consumers.
//
// Parameters
//   WIDTH   operand width in bits (>= 1). The carry ripples from LSB to MSB.
//
// Ports
//   clk     in   1      rising-edge clock, used only by the output register
//   rst_n   in   1      asynchronous active-low reset of the output register
//   A       in   WIDTH  unsigned addend
//   B       in   WIDTH  unsigned addend
//   Cin     in   1      carry into bit 0
//   S       out  WIDTH  combinational sum, (A + B + Cin) mod 2^WIDTH
//   Cout    out  1      combinational carry out of the MSB
//   S_q     out  WIDTH  S registered on the rising clk edge
//   Cout_q  out  1      Cout registered on the rising clk edge
// -----------------------------------------------------------------------------
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic [WIDTH-1:0] S_q,
    output logic             Cout_q
);

    // carry[i] is the carry into bit slice i; carry[WIDTH] leaves the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = Cin;

    // Each slice is two half adders. The first adds the operand bits and the
    // second folds in the incoming carry. Both carries cannot be 1 together,
    // so an OR merges them.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic ha1_s;
        logic ha1_c;
        logic ha2_c;

        half_adder u_ha1 (
            .a (A[i]),
            .b (B[i]),
            .s (ha1_s),
            .c (ha1_c)
        );

        half_adder u_ha2 (
            .a (ha1_s),
            .b (carry[i]),
            .s (sum[i]),
            .c (ha2_c)
        );

        assign carry[i+1] = ha1_c | ha2_c;
    end

    assign S    = sum;
    assign Cout = carry[WIDTH];

    // ---- output register stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_q    <= '0;
            Cout_q <= 1'b0;
        end else begin
            S_q    <= S;
            Cout_q <= Cout;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//   Self-checking bench for full_adder at WIDTH = 1, 4 and 8. Expected values
//   come from a truth table, fixed boundary constants, or plain integer
//   addition A + B + Cin.
// -----------------------------------------------------------------------------
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // WIDTH = 1 instance
    logic       a1, b1, cin1, s1, cout1, s1_q, cout1_q;
    // WIDTH = 4 instance
    logic [3:0] a4, b4, s4, s4_q;
    logic       cin4, cout4, cout4_q;
    // WIDTH = 8 instance
    logic [7:0] a8, b8, s8, s8_q;
    logic       cin8, cout8, cout8_q;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1),
        .S(s1), .Cout(cout1), .S_q(s1_q), .Cout_q(cout1_q)
    );

    full_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin4),
        .S(s4), .Cout(cout4), .S_q(s4_q), .Cout_q(cout4_q)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin8),
        .S(s8), .Cout(cout8), .S_q(s8_q), .Cout_q(cout8_q)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain unsigned addition with one extra result bit.
    function automatic logic [15:0] ref_sum(input int w, input int a,
                                            input int b, input int c);
        int total;
        total = a + b + c;
        return 16'(total % (1 << (w + 1)));
    endfunction

    // Expected {S,Cout} for the vectors A,B,Cin = 000..111, listed in that order.
    logic [1:0] tt_exp [8] = '{2'b00, 2'b10, 2'b10, 2'b01,
                               2'b10, 2'b01, 2'b01, 2'b11};

    initial begin
        rst_n = 1'b0;
        a1 = 0; b1 = 0; cin1 = 0;
        a4 = 0; b4 = 0; cin4 = 0;
        a8 = 0; b8 = 0; cin8 = 0;

        // Reset state, and the combinational path working while in reset.
        #2;
        check("rst_s1q",   {15'd0, s1_q},   16'd0);
        check("rst_cout1q", {15'd0, cout1_q}, 16'd0);
        check("rst_s8q",   {8'd0, s8_q},    16'd0);
        a1 = 1'b1;
        #1;
        check("rst_comb_s1", {15'd0, s1}, 16'd1);
        @(posedge clk); #1;
        check("rst_hold_s1q", {15'd0, s1_q}, 16'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive 1-bit truth table, one vector per 10 ns cycle.
        for (int v = 0; v < 8; v++) begin
            {a1, b1, cin1} = 3'(v);
            #1;
            check($sformatf("tt_comb_%0d", v), {14'd0, s1, cout1}, {14'd0, tt_exp[v]});
            @(posedge clk); #1;
            check($sformatf("tt_reg_%0d", v), {14'd0, s1_q, cout1_q}, {14'd0, tt_exp[v]});
            @(negedge clk);
        end

        // The combinational output follows A with no clock edge in between.
        {a1, b1, cin1} = 3'b000;
        @(posedge clk); #1;
        a1 = 1'b1;
        #1;
        check("comb_timing_s", {15'd0, s1}, 16'd1);
        check("comb_timing_sq", {15'd0, s1_q}, 16'd0);

        // On the registered path, the old values hold until the edge.
        {a1, b1, cin1} = 3'b111;
        #1;
        check("reg_pre_edge", {14'd0, s1_q, cout1_q}, 16'd0);
        check("reg_comb", {14'd0, s1, cout1}, 16'b11);
        @(posedge clk); #1;
        check("reg_post_edge", {14'd0, s1_q, cout1_q}, 16'b11);

        // Reset is asserted mid-cycle and clears the registers immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_q", {14'd0, s1_q, cout1_q}, 16'd0);
        check("async_rst_comb", {14'd0, s1, cout1}, 16'b11);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_hold", {14'd0, s1_q, cout1_q}, 16'd0);
        @(posedge clk); #1;
        check("rst_reload", {14'd0, s1_q, cout1_q}, 16'b11);

        // WIDTH = 4 boundary cases
        @(negedge clk);
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        #1;
        check("w4_ff_ff_1", {11'd0, cout4, s4}, 16'h1F);
        a4 = 4'h8; b4 = 4'h8; cin4 = 1'b0;
        #1;
        check("w4_8_8_0", {11'd0, cout4, s4}, 16'h10);
        a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0;
        #1;
        check("w4_7_1_0", {11'd0, cout4, s4}, 16'h08);
        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        #1;
        check("w4_zero", {11'd0, cout4, s4}, 16'h00);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        #1;
        check("w8_all_ones", {7'd0, cout8, s8}, 16'h1FF);
        @(posedge clk); #1;
        check("w4_zero_reg", {11'd0, cout4_q, s4_q}, 16'h00);
        check("w8_all_ones_reg", {7'd0, cout8_q, s8_q}, 16'h1FF);

        // Random vectors at WIDTH = 8, with WIDTH = 4 driven alongside.
        for (int n = 0; n < 1000; n++) begin
            logic [15:0] exp8, exp4;
            int ra, rb, rc, qa, qb, qc;
            @(negedge clk);
            ra = int'($urandom_range(255)); rb = int'($urandom_range(255));
            rc = int'($urandom_range(1));
            qa = int'($urandom_range(15));  qb = int'($urandom_range(15));
            qc = int'($urandom_range(1));
            a8 = 8'(ra); b8 = 8'(rb); cin8 = 1'(rc);
            a4 = 4'(qa); b4 = 4'(qb); cin4 = 1'(qc);
            exp8 = ref_sum(8, ra, rb, rc);
            exp4 = ref_sum(4, qa, qb, qc);
            #1;
            check("rnd8_comb", {7'd0, cout8, s8}, exp8);
            check("rnd4_comb", {11'd0, cout4, s4}, exp4);
            @(posedge clk); #1;
            check("rnd8_reg", {7'd0, cout8_q, s8_q}, exp8);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
